ingress_cpl_tag_ctrl: RTL and testbench

//  Non-posted read tag allocator/scheduler in front of ingress_parse_cpl_shap. Round-robin arbitrates
//  REQ_N read requesters (destinations) for free TLP tags, hands {dst,tag} to the TX request engine,

---
 rtl/ingress_cpl_tag_ctrl_pkg.sv | 18 +
 rtl/ingress_cpl_tag_ctrl_rr_arbiter.sv | 26 ++
 rtl/ingress_cpl_tag_ctrl.sv | 158 +++++++++++++++
 tb/tb_ingress_cpl_tag_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_cpl_tag_ctrl_pkg.sv
// Shared types for the non-posted read tag controller and the completion shaper tag table.
package ingress_cpl_tag_ctrl_pkg;

    localparam int TAG_W_DEF = 5;
    localparam int DST_W_DEF = 2;

    typedef struct packed {
        logic [DST_W_DEF-1:0] dst;
        logic [TAG_W_DEF-1:0] tag;
    } cpl_tag_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } tag_ctrl_st_e;

endpackage

// File: rtl/ingress_cpl_tag_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first active requester at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ingress_cpl_tag_ctrl.sv
// Non-posted read tag allocator: round-robin grants free tags to requesters, loads the
// completion shaper tag table, frees tags on final completion and supports drain.
//   state | meaning
//   IDLE  | waiting for a request and a free tag, or for drain_req
//   ISSUE | grant offered to TX engine, held until gnt_rdy
//   DRAIN | allocation stopped; drain_done once every tag has returned
module ingress_cpl_tag_ctrl
    import ingress_cpl_tag_ctrl_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF,
    parameter int DST_W = DST_W_DEF,
    parameter int REQ_N = 2**DST_W,
    parameter int T_W   = TAG_W + DST_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_N-1:0] req_valid,
    output logic [REQ_N-1:0] req_gnt,
    output logic [TAG_W-1:0] gnt_tag,
    output logic [DST_W-1:0] gnt_dst,
    output logic             gnt_valid,
    input  logic             gnt_rdy,
    output logic [T_W-1:0]   tag,
    output logic             tag_vld,
    input  logic [TAG_W-1:0] rel_tag,
    input  logic             rel_vld,
    input  logic             drain_req,
    output logic             drain_done,
    output logic [TAG_W:0]   outstanding,
    output logic             err_spur
);

    localparam int TAG_NUM = 2**TAG_W;
    localparam int CNT_W   = TAG_W + 1;

    tag_ctrl_st_e       state_q, state_d;
    logic [TAG_NUM-1:0] busy_q, busy_d;
    logic [DST_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [TAG_W-1:0]   gnt_tag_q, gnt_tag_d;
    logic [DST_W-1:0]   gnt_dst_q, gnt_dst_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic [CNT_W-1:0]   outstanding_q, busy_cnt;
    logic               err_spur_q;

    logic [REQ_N-1:0]   arb_gnt;
    logic [DST_W-1:0]   win_idx;
    logic [TAG_W-1:0]   free_tag;
    logic               any_free;
    logic               hs;

    rr_arbiter #(
        .N     (REQ_N),
        .PTR_W (DST_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < REQ_N; i++) begin
            if (arb_gnt[i]) win_idx = DST_W'(i);
        end
    end

    // Lowest-index free tag wins; scanning downward leaves the lowest one last.
    always_comb begin
        free_tag = '0;
        for (int i = TAG_NUM - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_tag = TAG_W'(i);
        end
    end

    assign any_free = ~&busy_q;
    assign hs       = (state_q == ISSUE) && gnt_rdy;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_tag_d   = gnt_tag_q;
        gnt_dst_d   = gnt_dst_q;
        gnt_valid_d = gnt_valid_q;

        // The offered tag is never busy, so a same-tag release cannot clear it here.
        if (rel_vld && busy_q[rel_tag]) busy_d[rel_tag] = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end else if (|req_valid && any_free) begin
                    gnt_tag_d   = free_tag;
                    gnt_dst_d   = win_idx;
                    gnt_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (gnt_rdy) begin
                    busy_d[gnt_tag_q] = 1'b1;
                    rr_ptr_d          = gnt_dst_q + 1'b1;
                    gnt_valid_d       = 1'b0;
                    state_d           = IDLE;
                end
            end
            DRAIN: begin
                if (!drain_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < TAG_NUM; i++) begin
            busy_cnt = busy_cnt + CNT_W'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            busy_q        <= '0;
            rr_ptr_q      <= '0;
            gnt_tag_q     <= '0;
            gnt_dst_q     <= '0;
            gnt_valid_q   <= 1'b0;
            outstanding_q <= '0;
            err_spur_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_tag_q     <= gnt_tag_d;
            gnt_dst_q     <= gnt_dst_d;
            gnt_valid_q   <= gnt_valid_d;
            outstanding_q <= busy_cnt;
            err_spur_q    <= rel_vld && !busy_q[rel_tag];
        end
    end

    always_comb begin
        req_gnt = '0;
        if (hs) req_gnt[gnt_dst_q] = 1'b1;
    end

    assign gnt_tag     = gnt_tag_q;
    assign gnt_dst     = gnt_dst_q;
    assign gnt_valid   = gnt_valid_q;
    assign tag         = {gnt_dst_q, gnt_tag_q};
    assign tag_vld     = hs;
    assign drain_done  = (state_q == DRAIN) && (outstanding_q == '0);
    assign outstanding = outstanding_q;
    assign err_spur    = err_spur_q;

endmodule

// File: tb/tb_ingress_cpl_tag_ctrl.sv
// Bench for ingress_cpl_tag_ctrl: directed scenarios plus random traffic, all checked each cycle
// against a transaction-level model of tag ownership, round-robin order and drain.
module tb_ingress_cpl_tag_ctrl;
    import ingress_cpl_tag_ctrl_pkg::*;

    localparam int TAG_W   = 5;
    localparam int DST_W   = 2;
    localparam int REQ_N   = 4;
    localparam int T_W     = 7;
    localparam int TAG_NUM = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [REQ_N-1:0] req_valid = '0;
    logic [REQ_N-1:0] req_gnt;
    logic [TAG_W-1:0] gnt_tag;
    logic [DST_W-1:0] gnt_dst;
    logic             gnt_valid;
    logic             gnt_rdy = 1'b0;
    logic [T_W-1:0]   tag;
    logic             tag_vld;
    logic [TAG_W-1:0] rel_tag = '0;
    logic             rel_vld = 1'b0;
    logic             drain_req = 1'b0;
    logic             drain_done;
    logic [TAG_W:0]   outstanding;
    logic             err_spur;

    ingress_cpl_tag_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_gnt     (req_gnt),
        .gnt_tag     (gnt_tag),
        .gnt_dst     (gnt_dst),
        .gnt_valid   (gnt_valid),
        .gnt_rdy     (gnt_rdy),
        .tag         (tag),
        .tag_vld     (tag_vld),
        .rel_tag     (rel_tag),
        .rel_vld     (rel_vld),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .outstanding (outstanding),
        .err_spur    (err_spur)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: set of owned tags, one pending offer, a round-robin pointer and a drain flag.
    bit m_busy[TAG_NUM];
    bit m_offer;
    int m_otag, m_odst, m_rr;
    bit m_drain, m_spur;
    int log_dst[$], log_tag[$];

    function automatic int m_count();
        int c = 0;
        foreach (m_busy[i]) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic m_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_offer = 1'b0; m_otag = 0; m_odst = 0; m_rr = 0;
        m_drain = 1'b0; m_spur = 1'b0;
    endtask

    task automatic m_step();
        bit nspur;
        int ft;
        nspur = rel_vld && !m_busy[rel_tag];
        if (m_offer) begin
            if (gnt_rdy) begin
                m_busy[m_otag] = 1'b1;
                m_rr    = (m_odst + 1) % REQ_N;
                m_offer = 1'b0;
            end
        end else if (m_drain) begin
            if (!drain_req) m_drain = 1'b0;
        end else if (drain_req) begin
            m_drain = 1'b1;
        end else if (req_valid != '0 && m_count() < TAG_NUM) begin
            for (int k = 0; k < REQ_N; k++) begin
                if (req_valid[(m_rr + k) % REQ_N]) begin
                    m_odst = (m_rr + k) % REQ_N;
                    break;
                end
            end
            ft = 0;
            while (m_busy[ft]) ft++;
            m_otag  = ft;
            m_offer = 1'b1;
        end
        if (rel_vld && !nspur) m_busy[rel_tag] = 1'b0;
        m_spur = nspur;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else     m_step();
    end

    always @(negedge clk) begin
        bit       hs;
        cpl_tag_t et;
        hs     = m_offer && gnt_rdy;
        et.dst = DST_W'(m_odst);
        et.tag = TAG_W'(m_otag);
        chk("gnt_valid", 32'(gnt_valid), 32'(m_offer));
        if (m_offer) begin
            chk("gnt_tag", 32'(gnt_tag), 32'(m_otag));
            chk("gnt_dst", 32'(gnt_dst), 32'(m_odst));
        end
        chk("req_gnt", 32'(req_gnt), hs ? (32'd1 << m_odst) : 32'd0);
        chk("tag_vld", 32'(tag_vld), 32'(hs));
        if (hs) chk("tag", 32'(tag), 32'(et));
        chk("outstanding", 32'(outstanding), 32'(m_count()));
        chk("err_spur", 32'(err_spur), 32'(m_spur));
        chk("drain_done", 32'(drain_done), 32'(m_drain && m_count() == 0));
        if (tag_vld) begin
            log_dst.push_back(int'(gnt_dst));
            log_tag.push_back(int'(gnt_tag));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        req_valid = '0; gnt_rdy = 1'b0; rel_vld = 1'b0; drain_req = 1'b0; rel_tag = '0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        log_dst.delete();
        log_tag.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_dst[5] = '{0, 1, 2, 3, 0};
        int nlog;

        // 1: first grant one cycle after request
        do_reset();
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'd0);
        req_valid = 4'b0001; gnt_rdy = 1'b1;
        tick(1);
        chk("t1_gnt_valid", 32'(gnt_valid), 32'd1);
        chk("t1_gnt_tag", 32'(gnt_tag), 32'd0);
        chk("t1_gnt_dst", 32'(gnt_dst), 32'd0);
        chk("t1_tag_vld", 32'(tag_vld), 32'd1);
        chk("t1_tag", 32'(tag), 32'h00);
        chk("t1_req_gnt", 32'(req_gnt), 32'd1);
        req_valid = '0;
        tick(1);
        chk("t1_outstanding", 32'(outstanding), 32'd1);

        // 2: round-robin order with all requesters active
        do_reset();
        req_valid = 4'b1111; gnt_rdy = 1'b1;
        tick(10);
        req_valid = '0;
        tick(2);
        chk("t2_count", 32'(log_dst.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_dst", (i < log_dst.size()) ? 32'(log_dst[i]) : 32'hffff, 32'(exp_dst[i]));
            chk("t2_tag", (i < log_tag.size()) ? 32'(log_tag[i]) : 32'hffff, 32'(i));
        end

        // 3: full table, then a single release re-enables allocation with that tag
        do_reset();
        req_valid = 4'b1111; gnt_rdy = 1'b1;
        for (int i = 0; i < 100 && outstanding != 6'd32; i++) tick(1);
        chk("t3_full", 32'(outstanding), 32'd32);
        tick(6);
        chk("t3_no_gnt", 32'(gnt_valid), 32'd0);
        rel_tag = 5'd5; rel_vld = 1'b1;
        tick(1);
        rel_vld = 1'b0;
        tick(1);
        chk("t3_regrant_valid", 32'(gnt_valid), 32'd1);
        chk("t3_regrant_tag", 32'(gnt_tag), 32'd5);
        req_valid = '0;
        tick(2);

        // 4: backpressure holds the offer
        do_reset();
        req_valid = 4'b0001; gnt_rdy = 1'b0;
        tick(11);
        chk("t4_hold_valid", 32'(gnt_valid), 32'd1);
        chk("t4_hold_tag", 32'(gnt_tag), 32'd0);
        chk("t4_hold_busy", 32'(outstanding), 32'd0);
        chk("t4_hold_tag_vld", 32'(tag_vld), 32'd0);
        gnt_rdy = 1'b1;
        #1;
        chk("t4_accept", 32'(tag_vld), 32'd1);
        req_valid = '0;
        tick(2);
        chk("t4_after", 32'(outstanding), 32'd1);

        // 5: spurious release, then handshake coinciding with a release
        do_reset();
        rel_tag = 5'd9; rel_vld = 1'b1;
        tick(1);
        rel_vld = 1'b0;
        chk("t5_spur", 32'(err_spur), 32'd1);
        chk("t5_spur_cnt", 32'(outstanding), 32'd0);
        tick(1);
        chk("t5_spur_once", 32'(err_spur), 32'd0);
        req_valid = 4'b0001; gnt_rdy = 1'b1;
        tick(5);
        rel_tag = 5'd0; rel_vld = 1'b1;
        tick(1);
        rel_vld = 1'b0; req_valid = '0;
        chk("t5_collide_cnt", 32'(outstanding), 32'd2);
        chk("t5_collide_spur", 32'(err_spur), 32'd0);
        tick(2);

        // 6: drain with 8 tags in flight
        do_reset();
        req_valid = 4'b1111; gnt_rdy = 1'b1;
        for (int i = 0; i < 40 && outstanding != 6'd8; i++) tick(1);
        req_valid = '0;
        chk("t6_busy8", 32'(outstanding), 32'd8);
        drain_req = 1'b1; req_valid = 4'b1111;
        nlog = log_dst.size();
        tick(10);
        chk("t6_no_grants", 32'(log_dst.size()), 32'(nlog));
        chk("t6_not_done", 32'(drain_done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rel_tag = 5'(i); rel_vld = 1'b1;
            tick(1);
        end
        rel_vld = 1'b0;
        tick(1);
        chk("t6_done", 32'(drain_done), 32'd1);
        drain_req = 1'b0;
        tick(2);
        chk("t6_resume", 32'(gnt_valid), 32'd1);
        req_valid = '0;
        tick(2);

        // Random traffic with a mid-run asynchronous reset
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 2) == 0) req_valid = 4'($urandom_range(0, 15));
            gnt_rdy = ($urandom_range(0, 9) < 7);
            rel_vld = ($urandom_range(0, 9) < 3);
            rel_tag = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
            if ($urandom_range(0, 149) == 0) drain_req = !drain_req;
            if (c == 2000) begin
                #2 rst = 1'b1;
                #4 rst = 1'b0;
            end
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
